// File: rtl/if_stage.sv
// Instruction Fetch stage: PC register, instruction memory with a byte-serial
// program loader, and HALT detection that freezes fetch so the pipeline drains.
module if_stage #(
  parameter int unsigned         NB_INSTR   = 32,
  parameter int unsigned         NB_PC      = 32,
  parameter int unsigned         NB_ADDR    = 8,
  parameter int unsigned         NB_BYTE    = 8,
  parameter logic [NB_INSTR-1:0] HALT_INSTR = 32'h00000073,
  parameter logic [NB_INSTR-1:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic                i_stall,
  input  logic                i_pc_src,
  input  logic [NB_PC-1:0]    i_pc_target,
  input  logic                i_load_start,
  input  logic                i_load_valid,
  input  logic [NB_BYTE-1:0]  i_load_byte,
  output logic [NB_INSTR-1:0] o_instr,
  output logic [NB_PC-1:0]    o_pc,
  output logic [NB_PC-1:0]    o_pc_next,
  output logic                o_halted,
  output logic                o_loading,
  output logic                o_load_done
);

  localparam int unsigned MEM_WORDS      = 2**NB_ADDR;
  localparam int unsigned BYTES_PER_WORD = NB_INSTR / NB_BYTE;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [0:0]          state_q,    state_d;
  logic [NB_PC-1:0]    pc_q,       pc_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [NB_ADDR-1:0]  word_ptr_q, word_ptr_d;
  logic [NB_INSTR-1:0] word_buf_q, word_buf_d;
  logic                halted_q,   halted_d;
  logic                done_q,     done_d;

  logic                mem_we;
  logic [NB_INSTR-1:0] mem_wdata;
  logic [NB_INSTR-1:0] mem [MEM_WORDS];
  logic [NB_ADDR-1:0]  fetch_idx;
  logic [NB_INSTR-1:0] fetch_word;

  // Redirect targets are word-aligned, so the low target bits are dropped.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^i_pc_target[1:0];

  // PC wraps modulo the memory size through this index slice.
  assign fetch_idx  = pc_q[NB_ADDR+1:2];
  assign fetch_word = mem[fetch_idx];

  // Next-state logic: load start has priority, then loader or fetch by state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_cnt_d = byte_cnt_q;
    word_ptr_d = word_ptr_q;
    word_buf_d = word_buf_q;
    halted_d   = halted_q;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = word_buf_q;

    if (i_load_start) begin
      state_d    = ST_LOAD;
      pc_d       = '0;
      word_ptr_d = '0;
      byte_cnt_d = '0;
      halted_d   = 1'b0;
    end else if (state_q == ST_LOAD) begin
      if (i_load_valid) begin
        word_buf_d[int'(byte_cnt_q)*NB_BYTE +: NB_BYTE] = i_load_byte;
        if (byte_cnt_q == CNT_W'(BYTES_PER_WORD-1)) begin
          // Final byte goes straight into memory along with the buffered lanes.
          mem_we     = 1'b1;
          mem_wdata  = word_buf_d;
          byte_cnt_d = '0;
          word_ptr_d = word_ptr_q + 1'b1;
          if (word_buf_d == HALT_INSTR || word_ptr_q == '1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
    end else begin
      if (i_en && !i_stall && !halted_q) begin
        if (i_pc_src) begin
          pc_d = {i_pc_target[NB_PC-1:2], 2'b00};
        end else if (fetch_word == HALT_INSTR) begin
          halted_d = 1'b1;
        end else begin
          pc_d = pc_q + NB_PC'(4);
        end
      end
    end
  end

  // Control and PC registers; memory contents are deliberately not reset.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      byte_cnt_q <= '0;
      word_ptr_q <= '0;
      word_buf_q <= '0;
      halted_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_cnt_q <= byte_cnt_d;
      word_ptr_q <= word_ptr_d;
      word_buf_q <= word_buf_d;
      halted_q   <= halted_d;
      done_q     <= done_d;
    end
  end

  // Instruction memory write port, driven only by the loader.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[word_ptr_q] <= mem_wdata;
    end
  end

  // Bubbles are issued while loading or halted.
  always_comb begin
    o_instr = fetch_word;
    o_pc    = pc_q;
    if (state_q == ST_LOAD) begin
      o_instr = NOP_INSTR;
      o_pc    = '0;
    end else if (halted_q) begin
      o_instr = NOP_INSTR;
    end
  end

  assign o_pc_next   = o_pc + NB_PC'(4);
  assign o_halted    = halted_q;
  assign o_loading   = (state_q == ST_LOAD);
  assign o_load_done = done_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: program loads, fetch/stall/redirect table,
// halt behaviour, reset during a load and a full-memory load with PC wrap.
module tb_if_stage;

  localparam logic [31:0] HALT = 32'h00000073;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        i_rst, i_en, i_stall, i_pc_src, i_load_start, i_load_valid;
  logic [31:0] i_pc_target;
  logic [7:0]  i_load_byte;
  logic [31:0] o_instr, o_pc, o_pc_next;
  logic        o_halted, o_loading, o_load_done;

  int n_vec = 0;
  int n_err = 0;

  if_stage #(.NB_INSTR(32), .NB_PC(32), .NB_ADDR(8), .NB_BYTE(8)) dut (
    .clk(clk), .i_rst(i_rst), .i_en(i_en), .i_stall(i_stall),
    .i_pc_src(i_pc_src), .i_pc_target(i_pc_target),
    .i_load_start(i_load_start), .i_load_valid(i_load_valid),
    .i_load_byte(i_load_byte), .o_instr(o_instr), .o_pc(o_pc),
    .o_pc_next(o_pc_next), .o_halted(o_halted), .o_loading(o_loading),
    .o_load_done(o_load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, stall, src;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic        chk_instr;
    logic [31:0] exp_instr;
    logic        exp_halt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    i_load_valid = 1'b1;
    i_load_byte  = b;
    tick();
    i_load_valid = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      load_byte(w[8*i +: 8]);
    end
  endtask

  task automatic step(input logic en, input logic stall, input logic src, input logic [31:0] tgt);
    i_en = en; i_stall = stall; i_pc_src = src; i_pc_target = tgt;
    tick();
    i_en = 1'b0; i_stall = 1'b0; i_pc_src = 1'b0;
  endtask

  initial begin
    //            en    stall src   tgt           exp_pc        chk   exp_instr     halt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,       32'h4,        1'b1, 32'h00A00593, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h4,        1'b1, 32'h00A00593, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h40,      32'h4,        1'b1, 32'h00A00593, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h40,      32'h4,        1'b1, 32'h00A00593, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h40,      32'h40,       1'b0, 32'h0,        1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h43,      32'h40,       1'b0, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h8,       32'h8,        1'b1, HALT,         1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'h0,       32'h0,        1'b1, 32'h00500513, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,       32'h4,        1'b1, 32'h00A00593, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,       32'h8,        1'b1, HALT,         1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h0,       32'h8,        1'b1, NOP,          1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h0,       32'h8,        1'b1, NOP,          1'b1};

    i_rst = 1'b1; i_en = 1'b0; i_stall = 1'b0; i_pc_src = 1'b0; i_pc_target = '0;
    i_load_start = 1'b0; i_load_valid = 1'b0; i_load_byte = '0;
    #12;
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_pc_next", o_pc_next, 32'h4);
    chk("rst_halted", {31'b0, o_halted}, 32'h0);
    chk("rst_loading", {31'b0, o_loading}, 32'h0);
    chk("rst_done", {31'b0, o_load_done}, 32'h0);
    @(negedge clk);
    i_rst = 1'b0;
    tick();

    // Load ADDI + HALT; loader stops on the HALT word.
    start_load();
    chk("ld1_loading", {31'b0, o_loading}, 32'h1);
    chk("ld1_nop", o_instr, NOP);
    load_word(32'h00500513);
    chk("ld1_mid_done", {31'b0, o_load_done}, 32'h0);
    load_word(HALT);
    chk("ld1_done", {31'b0, o_load_done}, 32'h1);
    chk("ld1_loading_off", {31'b0, o_loading}, 32'h0);
    chk("ld1_pc", o_pc, 32'h0);
    chk("ld1_mem0", o_instr, 32'h00500513);
    tick();
    chk("ld1_done_pulse", {31'b0, o_load_done}, 32'h0);

    // Run into the HALT at word 1.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("h1_pc", o_pc, 32'h4);
    chk("h1_instr", o_instr, HALT);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("h1_halted", {31'b0, o_halted}, 32'h1);
    chk("h1_pc_hold", o_pc, 32'h4);
    chk("h1_nop", o_instr, NOP);

    // Load start while halted clears the halt.
    start_load();
    chk("rl_halted", {31'b0, o_halted}, 32'h0);
    chk("rl_pc", o_pc, 32'h0);
    load_word(32'h00500513);
    load_word(32'h00A00593);
    load_word(HALT);
    chk("ld2_done", {31'b0, o_load_done}, 32'h1);
    chk("ld2_instr0", o_instr, 32'h00500513);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].stall, vecs[i].src, vecs[i].tgt);
      chk($sformatf("vec%0d_pc", i), o_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_pc_next", i), o_pc_next, vecs[i].exp_pc + 32'h4);
      chk($sformatf("vec%0d_halted", i), {31'b0, o_halted}, {31'b0, vecs[i].exp_halt});
      if (vecs[i].chk_instr) begin
        chk($sformatf("vec%0d_instr", i), o_instr, vecs[i].exp_instr);
      end
    end

    // Asynchronous reset in the middle of a word (two bytes in).
    start_load();
    load_word(32'h00100093);
    load_byte(8'hAA);
    load_byte(8'hBB);
    i_rst = 1'b1;
    #1;
    chk("ar_loading", {31'b0, o_loading}, 32'h0);
    chk("ar_pc", o_pc, 32'h0);
    chk("ar_halted", {31'b0, o_halted}, 32'h0);
    @(negedge clk);
    i_rst = 1'b0;
    tick();
    chk("ar_mem0", o_instr, 32'h00100093);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("ar_mem1_kept", o_instr, 32'h00A00593);

    // Fill every word without a HALT; done only after the last write.
    start_load();
    for (int k = 0; k < 255; k++) begin
      load_word({16'h0, 8'(k), 8'h13});
    end
    chk("full_loading", {31'b0, o_loading}, 32'h1);
    chk("full_no_done", {31'b0, o_load_done}, 32'h0);
    load_word(32'h0000FF13);
    chk("full_done", {31'b0, o_load_done}, 32'h1);
    chk("full_idle", {31'b0, o_loading}, 32'h0);
    tick();
    chk("full_done_pulse", {31'b0, o_load_done}, 32'h0);
    chk("full_mem0", o_instr, 32'h00000013);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("full_mem1", o_instr, 32'h00000113);

    // Index wraps modulo memory size.
    step(1'b1, 1'b0, 1'b1, 32'h000003FC);
    chk("wrap_pc", o_pc, 32'h3FC);
    chk("wrap_last", o_instr, 32'h0000FF13);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc2", o_pc, 32'h400);
    chk("wrap_pc_next", o_pc_next, 32'h404);
    chk("wrap_first", o_instr, 32'h00000013);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
